bp_fe_icache_refetch_buffer: RTL and testbench

//  Downstream of the I$ response port. Buffers in-order hit responses for the fetch consumer.

---
 rtl/bp_fe_pkg.sv | 19 +
 rtl/bp_fe_resp_ring.sv | 56 +++++
 rtl/bp_fe_icache_refetch_buffer.sv | 141 ++++++++++++++
 tb/tb_bp_fe_icache_refetch_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// Shared types for the front-end I$ refetch buffer: FSM states and the
// default response-entry layout stored in the ring.
package bp_fe_pkg;

  localparam int bp_fe_vaddr_width_gp = 39;
  localparam int bp_fe_instr_width_gp = 32;

  typedef enum logic [1:0] {
    e_run  = 2'd0,
    e_req  = 2'd1,
    e_wait = 2'd2
  } bp_fe_refetch_state_e;

  typedef struct packed {
    logic [bp_fe_vaddr_width_gp-1:0] vaddr;
    logic [bp_fe_instr_width_gp-1:0] instr;
  } bp_fe_resp_entry_s;

endpackage

// File: rtl/bp_fe_resp_ring.sv
// els_p-entry 1r1w register ring with wrapping pointers and exact occupancy.
// Head data reads as zero while empty so outputs are clean after reset/flush.
module bp_fe_resp_ring #(
  parameter int els_p   = 16,
  parameter int width_p = 71
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         flush_i,
  input  logic                         enq_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         deq_i,
  output logic [width_p-1:0]           data_o,
  output logic [$clog2(els_p+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p+1);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr;
  logic [ptr_w_lp-1:0] r_rptr;
  logic [cnt_w_lp-1:0] r_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (enq_i) r_wptr <= r_wptr + ptr_w_lp'(1);
      if (deq_i) r_rptr <= r_rptr + ptr_w_lp'(1);
      case ({enq_i, deq_i})
        2'b10:   r_count <= r_count + cnt_w_lp'(1);
        2'b01:   r_count <= r_count - cnt_w_lp'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_i) r_mem[r_wptr] <= data_i;
  end

  assign full_o  = (r_count == cnt_w_lp'(els_p));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = empty_o ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/bp_fe_icache_refetch_buffer.sv
// Buffers in-order I$ hits for fetch; a miss triggers a refetch request and
// wrong-path responses are dropped until the refetched vaddr comes back.
module bp_fe_icache_refetch_buffer
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p = bp_fe_vaddr_width_gp,
  parameter int instr_width_p = bp_fe_instr_width_gp,
  parameter int els_p         = 16,
  parameter int retry_max_p   = 3
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        flush_i,
  input  logic                        icache_v_i,
  input  logic [vaddr_width_p-1:0]    icache_vaddr_i,
  input  logic [instr_width_p-1:0]    icache_data_i,
  input  logic                        icache_miss_not_data_i,
  output logic                        icache_yumi_o,
  output logic                        fetch_v_o,
  output logic [vaddr_width_p-1:0]    fetch_vaddr_o,
  output logic [instr_width_p-1:0]    fetch_data_o,
  input  logic                        fetch_yumi_i,
  output logic                        refetch_v_o,
  output logic [vaddr_width_p-1:0]    refetch_vaddr_o,
  output logic                        refetch_fill_o,
  input  logic                        refetch_ready_i,
  output logic [$clog2(els_p+1)-1:0]  count_o,
  output logic                        err_o,
  output logic [1:0]                  dbg_state_o
);

  localparam int entry_w_lp = vaddr_width_p + instr_width_p;
  localparam int retry_w_lp = $clog2(retry_max_p+1);

  bp_fe_refetch_state_e     r_state, w_state_n;
  logic [vaddr_width_p-1:0] r_vaddr;
  logic [retry_w_lp-1:0]    r_retry, w_retry_n, w_retry_inc;
  logic                     r_err;
  logic                     w_yumi, w_enq, w_deq, w_latch, w_err_set;
  logic                     w_full, w_empty, w_match;
  logic [entry_w_lp-1:0]    w_head;

  assign w_match     = (icache_vaddr_i == r_vaddr);
  assign w_retry_inc = (r_retry == retry_w_lp'(retry_max_p)) ? r_retry
                                                             : r_retry + retry_w_lp'(1);

  // Handshake: a response is consumed or dropped exactly when icache_v_i && icache_yumi_o;
  // the refetch request transfers when refetch_v_o && refetch_ready_i.
  always_comb begin
    w_state_n = r_state;
    w_retry_n = r_retry;
    w_yumi    = 1'b0;
    w_enq     = 1'b0;
    w_latch   = 1'b0;
    w_err_set = 1'b0;
    if (flush_i) begin
      w_state_n = e_run;
      w_retry_n = '0;
    end else begin
      case (r_state)
        e_run: begin
          if (icache_v_i) begin
            if (icache_miss_not_data_i) begin
              w_yumi    = 1'b1;
              w_latch   = 1'b1;
              w_state_n = e_req;
            end else if (!w_full) begin
              w_yumi = 1'b1;
              w_enq  = 1'b1;
            end
          end
        end
        e_req: begin
          w_yumi = icache_v_i;
          if (refetch_ready_i) w_state_n = e_wait;
        end
        e_wait: begin
          if (icache_v_i) begin
            if (!w_match) begin
              w_yumi = 1'b1;
            end else if (icache_miss_not_data_i) begin
              w_yumi    = 1'b1;
              w_retry_n = w_retry_inc;
              w_err_set = (w_retry_inc == retry_w_lp'(retry_max_p));
              w_state_n = e_req;
            end else if (!w_full) begin
              w_yumi    = 1'b1;
              w_enq     = 1'b1;
              w_retry_n = '0;
              w_state_n = e_run;
            end
          end
        end
        default: w_state_n = e_run;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= e_run;
      r_vaddr <= '0;
      r_retry <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_retry <= w_retry_n;
      if (w_latch)   r_vaddr <= icache_vaddr_i;
      if (w_err_set) r_err   <= 1'b1;
    end
  end

  assign w_deq = fetch_yumi_i && !w_empty && !flush_i;

  bp_fe_resp_ring #(
    .els_p   (els_p),
    .width_p (entry_w_lp)
  ) ring (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .flush_i   (flush_i),
    .enq_i     (w_enq),
    .data_i    ({icache_vaddr_i, icache_data_i}),
    .deq_i     (w_deq),
    .data_o    (w_head),
    .count_o   (count_o),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  assign icache_yumi_o   = w_yumi;
  assign fetch_v_o       = !w_empty;
  assign fetch_vaddr_o   = w_head[entry_w_lp-1 -: vaddr_width_p];
  assign fetch_data_o    = w_head[instr_width_p-1:0];
  assign refetch_v_o     = (r_state == e_req);
  assign refetch_vaddr_o = r_vaddr;
  assign refetch_fill_o  = 1'b1;
  assign err_o           = r_err;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_bp_fe_icache_refetch_buffer.sv
// Directed bench for the refetch buffer: streaming, refetch/drop, retry error,
// flush and async reset, with hand-computed expectations.
module tb_bp_fe_icache_refetch_buffer;
  import bp_fe_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        flush_i;
  logic        icache_v_i;
  logic [38:0] icache_vaddr_i;
  logic [31:0] icache_data_i;
  logic        icache_miss_not_data_i;
  logic        icache_yumi_o;
  logic        fetch_v_o;
  logic [38:0] fetch_vaddr_o;
  logic [31:0] fetch_data_o;
  logic        fetch_yumi_i;
  logic        refetch_v_o;
  logic [38:0] refetch_vaddr_o;
  logic        refetch_fill_o;
  logic        refetch_ready_i;
  logic [4:0]  count_o;
  logic        err_o;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  bp_fe_resp_entry_s exp_e;

  always #5 clk = ~clk;

  bp_fe_icache_refetch_buffer dut (
    .clk_i                  (clk),
    .reset_n_i              (reset_n_i),
    .flush_i                (flush_i),
    .icache_v_i             (icache_v_i),
    .icache_vaddr_i         (icache_vaddr_i),
    .icache_data_i          (icache_data_i),
    .icache_miss_not_data_i (icache_miss_not_data_i),
    .icache_yumi_o          (icache_yumi_o),
    .fetch_v_o              (fetch_v_o),
    .fetch_vaddr_o          (fetch_vaddr_o),
    .fetch_data_o           (fetch_data_o),
    .fetch_yumi_i           (fetch_yumi_i),
    .refetch_v_o            (refetch_v_o),
    .refetch_vaddr_o        (refetch_vaddr_o),
    .refetch_fill_o         (refetch_fill_o),
    .refetch_ready_i        (refetch_ready_i),
    .count_o                (count_o),
    .err_o                  (err_o),
    .dbg_state_o            (dbg_state_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [38:0] va, input logic [31:0] d, input logic miss);
    icache_v_i             = v;
    icache_vaddr_i         = va;
    icache_data_i          = d;
    icache_miss_not_data_i = miss;
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b0; flush_i = 1'b0; fetch_yumi_i = 1'b0; refetch_ready_i = 1'b0;
    icache_v_i = 1'b0; icache_vaddr_i = '0; icache_data_i = '0; icache_miss_not_data_i = 1'b0;
    #3;
    chk("rst_fetch_v", fetch_v_o, 0);
    chk("rst_refetch_v", refetch_v_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_yumi", icache_yumi_o, 0);
    chk("rst_state", dbg_state_o, 0);
    chk("rst_fill", refetch_fill_o, 1);
    #19 reset_n_i = 1'b1;
    step();

    // Stream 16 hits with no consumer, then a 17th that must stall.
    for (int i = 0; i < 16; i++) begin
      drive(1, 39'h8000_0000 + 39'(4*i), 32'h100 + 32'(i), 0);
      chk("stream_yumi", icache_yumi_o, 1);
      step();
    end
    chk("full_count", count_o, 16);
    drive(1, 39'h8000_0040, 32'h1ff, 0);
    chk("full_yumi", icache_yumi_o, 0);
    step();
    chk("full_count_hold", count_o, 16);
    drive(0, '0, '0, 0);
    fetch_yumi_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_e.vaddr = 39'h8000_0000 + 39'(4*i);
      exp_e.instr = 32'h100 + 32'(i);
      chk("drain_v", fetch_v_o, 1);
      chk("drain_vaddr", fetch_vaddr_o, exp_e.vaddr);
      chk("drain_data", fetch_data_o, exp_e.instr);
      step();
    end
    fetch_yumi_i = 1'b0;
    #1;
    chk("drain_empty_v", fetch_v_o, 0);
    chk("drain_empty_count", count_o, 0);

    // Hit then miss: refetch raised next cycle, wrong-path responses dropped.
    drive(1, 39'h8000_0000, 32'h10, 0);
    chk("b_hit_yumi", icache_yumi_o, 1);
    step();
    drive(1, 39'h8000_0004, 32'hdead, 1);
    chk("b_miss_yumi", icache_yumi_o, 1);
    step();
    chk("b_refetch_v", refetch_v_o, 1);
    chk("b_refetch_vaddr", refetch_vaddr_o, 39'h8000_0004);
    chk("b_state_req", dbg_state_o, 1);
    chk("b_count_after_miss", count_o, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 39'h8000_0008, 32'h77, 0);
      chk("req_drop_yumi", icache_yumi_o, 1);
      chk("req_hold_v", refetch_v_o, 1);
      chk("req_hold_vaddr", refetch_vaddr_o, 39'h8000_0004);
      step();
    end
    chk("req_count_unchanged", count_o, 1);
    drive(0, '0, '0, 0);
    refetch_ready_i = 1'b1;
    #1;
    chk("req_v_at_ready", refetch_v_o, 1);
    step();
    refetch_ready_i = 1'b0;
    chk("wait_state", dbg_state_o, 2);
    chk("wait_refetch_v", refetch_v_o, 0);
    drive(1, 39'h8000_0010, 32'h55, 0);
    chk("wait_drop_yumi", icache_yumi_o, 1);
    step();
    chk("wait_drop_count", count_o, 1);
    chk("wait_still", dbg_state_o, 2);
    // Matching hit enqueues while the consumer dequeues the older head.
    drive(1, 39'h8000_0004, 32'h13, 0);
    fetch_yumi_i = 1'b1;
    #1;
    chk("match_yumi", icache_yumi_o, 1);
    chk("match_head_vaddr", fetch_vaddr_o, 39'h8000_0000);
    chk("match_head_data", fetch_data_o, 32'h10);
    step();
    fetch_yumi_i = 1'b0;
    drive(0, '0, '0, 0);
    chk("enqdeq_count", count_o, 1);
    chk("match_state_run", dbg_state_o, 0);
    chk("refetched_vaddr", fetch_vaddr_o, 39'h8000_0004);
    chk("refetched_data", fetch_data_o, 32'h13);
    fetch_yumi_i = 1'b1;
    step();
    fetch_yumi_i = 1'b0;
    #1;
    chk("b_final_empty", fetch_v_o, 0);

    // Four consecutive misses on one vaddr: err after the third retry miss.
    drive(1, 39'h8000_0040, 32'h0, 1);
    step();
    chk("c_state_req", dbg_state_o, 1);
    for (int i = 1; i <= 3; i++) begin
      drive(0, '0, '0, 0);
      refetch_ready_i = 1'b1;
      step();
      refetch_ready_i = 1'b0;
      chk("c_err_before", err_o, 0);
      drive(1, 39'h8000_0040, 32'h0, 1);
      chk("c_retry_yumi", icache_yumi_o, 1);
      step();
      chk("c_err", err_o, (i == 3) ? 1 : 0);
      chk("c_refetch_v", refetch_v_o, 1);
      chk("c_refetch_vaddr", refetch_vaddr_o, 39'h8000_0040);
    end

    // Flush in e_req with a response pending: nothing consumed, err sticky.
    drive(1, 39'h8000_0040, 32'h0, 0);
    flush_i = 1'b1;
    #1;
    chk("flush1_yumi", icache_yumi_o, 0);
    step();
    flush_i = 1'b0;
    drive(0, '0, '0, 0);
    chk("flush1_state", dbg_state_o, 0);
    chk("flush1_refetch_v", refetch_v_o, 0);
    chk("flush1_err_sticky", err_o, 1);

    // Seven entries, then miss into e_wait, then flush.
    for (int i = 0; i < 7; i++) begin
      drive(1, 39'h8000_0200 + 39'(4*i), 32'h200 + 32'(i), 0);
      step();
    end
    drive(1, 39'h8000_0100, 32'h0, 1);
    step();
    drive(0, '0, '0, 0);
    refetch_ready_i = 1'b1;
    step();
    refetch_ready_i = 1'b0;
    chk("d_count7", count_o, 7);
    chk("d_state_wait", dbg_state_o, 2);
    drive(1, 39'h8000_0100, 32'h9, 0);
    fetch_yumi_i = 1'b1;
    flush_i = 1'b1;
    #1;
    chk("flush2_yumi", icache_yumi_o, 0);
    step();
    flush_i = 1'b0;
    fetch_yumi_i = 1'b0;
    drive(0, '0, '0, 0);
    chk("flush2_count", count_o, 0);
    chk("flush2_state", dbg_state_o, 0);
    chk("flush2_refetch_v", refetch_v_o, 0);
    chk("flush2_fetch_v", fetch_v_o, 0);
    chk("flush2_err", err_o, 1);

    // Full uses registered count: a dequeue does not open a slot the same cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1, 39'h8000_0300 + 39'(4*i), 32'h300 + 32'(i), 0);
      step();
    end
    drive(1, 39'h8000_0340, 32'h340, 0);
    fetch_yumi_i = 1'b1;
    #1;
    chk("fullyumi_yumi", icache_yumi_o, 0);
    step();
    fetch_yumi_i = 1'b0;
    drive(0, '0, '0, 0);
    chk("fullyumi_count", count_o, 15);
    chk("fullyumi_head", fetch_vaddr_o, 39'h8000_0304);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("e_flush_count", count_o, 0);

    // Mid-stream async reset while a refetch is outstanding.
    for (int i = 0; i < 3; i++) begin
      drive(1, 39'h8000_0400 + 39'(4*i), 32'h400 + 32'(i), 0);
      step();
    end
    drive(1, 39'h8000_0500, 32'h0, 1);
    step();
    drive(0, '0, '0, 0);
    chk("e_pre_refetch_v", refetch_v_o, 1);
    chk("e_pre_count", count_o, 3);
    #1 reset_n_i = 1'b0;
    #2;
    chk("e_rst_refetch_v", refetch_v_o, 0);
    chk("e_rst_count", count_o, 0);
    chk("e_rst_fetch_v", fetch_v_o, 0);
    chk("e_rst_err", err_o, 0);
    chk("e_rst_state", dbg_state_o, 0);
    chk("e_rst_refetch_vaddr", refetch_vaddr_o, 0);
    #2 reset_n_i = 1'b1;
    step();
    chk("e_post_count", count_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
